// File: rtl/dwt2d_haar_stream_if.sv
// Row-in / subband-out stream bundle for the 2D Haar wavelet stage.
// The master side feeds rows and drains beats; the slave side is the transform.
interface dwt2d_haar_stream_if #(
    parameter int PIX_W = 8,
    parameter int N     = 8,
    parameter int CW    = PIX_W + 3,
    parameter int IDX_W = 4
);
    logic                  in_valid;
    logic                  in_ready;
    logic [N*PIX_W-1:0]    in_row;
    logic                  in_last;
    logic                  mode;
    logic                  out_valid;
    logic                  out_ready;
    logic [(N/2)*CW-1:0]   out_ll;
    logic [(N/2)*CW-1:0]   out_hl;
    logic [(N/2)*CW-1:0]   out_lh;
    logic [(N/2)*CW-1:0]   out_hh;
    logic                  out_last;
    logic [IDX_W-1:0]      out_idx;
    logic                  err_odd;

    modport master (
        output in_valid, in_row, in_last, mode, out_ready,
        input  in_ready, out_valid, out_ll, out_hl, out_lh, out_hh,
               out_last, out_idx, err_odd
    );

    modport slave (
        input  in_valid, in_row, in_last, mode, out_ready,
        output in_ready, out_valid, out_ll, out_hl, out_lh, out_hh,
               out_last, out_idx, err_odd
    );
endinterface

// File: rtl/dwt2d_haar_stream.sv
// Streaming 2D Haar transform: buffers the even row of each pair and, when the
// odd row arrives, produces LL/HL/LH/HH for the whole pair in one output beat.
module dwt2d_haar_stream #(
    parameter int PIX_W = 8,
    parameter int N     = 8,
    parameter int CW    = PIX_W + 3,
    parameter int IDX_W = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    dwt2d_haar_stream_if.slave   bus
);
    localparam int HALF  = N / 2;
    localparam int BUS_W = HALF * CW;

    typedef enum logic {EVEN, ODD} phase_t;

    phase_t             state;
    phase_t             state_next;
    logic               ready;
    logic               even_fire;
    logic               odd_fire;
    logic [N*PIX_W-1:0] row_buf;
    logic               mode_q;
    logic [IDX_W-1:0]   pair_cnt;
    logic [BUS_W-1:0]   ll_next;
    logic [BUS_W-1:0]   hl_next;
    logic [BUS_W-1:0]   lh_next;
    logic [BUS_W-1:0]   hh_next;

    // Phase register: which row of the pair the next accepted row will be.
    always_ff @(posedge clk) begin
        if (!rst_n) state <= EVEN;
        else        state <= state_next;
    end

    // Handshake decode; only the odd row waits on the output register.
    always_comb begin
        state_next = state;
        ready      = 1'b0;
        even_fire  = 1'b0;
        odd_fire   = 1'b0;
        if (rst_n) begin
            unique case (state)
                EVEN: begin
                    ready = 1'b1;
                    if (bus.in_valid) begin
                        even_fire = 1'b1;
                        if (!bus.in_last) state_next = ODD;
                    end
                end
                ODD: begin
                    ready = !bus.out_valid || bus.out_ready;
                    if (bus.in_valid && ready) begin
                        odd_fire   = 1'b1;
                        state_next = EVEN;
                    end
                end
                default: state_next = EVEN;
            endcase
        end
    end

    assign bus.in_ready = ready;

    // Even-row buffer and the normalisation mode that goes with the pair.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            row_buf <= '0;
            mode_q  <= 1'b0;
        end else if (even_fire) begin
            row_buf <= bus.in_row;
            mode_q  <= bus.mode;
        end
    end

    // One butterfly per output column: sums and differences of the 2x2 block.
    for (genvar k = 0; k < HALF; k++) begin : g_lane
        logic signed [CW-1:0] a0, a1, b0, b1;
        logic signed [CW-1:0] sa, da, sb, db;
        logic signed [CW-1:0] ll, hl, lh, hh;

        assign a0 = $signed({{(CW-PIX_W){1'b0}}, row_buf[(2*k)*PIX_W +: PIX_W]});
        assign a1 = $signed({{(CW-PIX_W){1'b0}}, row_buf[(2*k+1)*PIX_W +: PIX_W]});
        assign b0 = $signed({{(CW-PIX_W){1'b0}}, bus.in_row[(2*k)*PIX_W +: PIX_W]});
        assign b1 = $signed({{(CW-PIX_W){1'b0}}, bus.in_row[(2*k+1)*PIX_W +: PIX_W]});

        assign sa = a0 + a1;
        assign da = a0 - a1;
        assign sb = b0 + b1;
        assign db = b0 - b1;

        assign ll = sa + sb;
        assign hl = da + db;
        assign lh = sa - sb;
        assign hh = da - db;

        assign ll_next[k*CW +: CW] = mode_q ? (ll >>> 2) : ll;
        assign hl_next[k*CW +: CW] = mode_q ? (hl >>> 2) : hl;
        assign lh_next[k*CW +: CW] = mode_q ? (lh >>> 2) : lh;
        assign hh_next[k*CW +: CW] = mode_q ? (hh >>> 2) : hh;
    end

    // Output beat register, tile framing, pair counter and sticky odd-tile error.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bus.out_valid <= 1'b0;
            bus.out_ll    <= '0;
            bus.out_hl    <= '0;
            bus.out_lh    <= '0;
            bus.out_hh    <= '0;
            bus.out_last  <= 1'b0;
            bus.out_idx   <= '0;
            bus.err_odd   <= 1'b0;
            pair_cnt      <= '0;
        end else begin
            if (odd_fire) begin
                bus.out_valid <= 1'b1;
                bus.out_ll    <= ll_next;
                bus.out_hl    <= hl_next;
                bus.out_lh    <= lh_next;
                bus.out_hh    <= hh_next;
                bus.out_last  <= bus.in_last;
                bus.out_idx   <= pair_cnt;
                pair_cnt      <= bus.in_last ? '0 : pair_cnt + 1'b1;
            end else if (bus.out_ready) begin
                bus.out_valid <= 1'b0;
            end
            if (even_fire && bus.in_last) begin
                bus.err_odd <= 1'b1;
                pair_cnt    <= '0;
            end
        end
    end
endmodule

// File: tb/tb_dwt2d_haar_stream.sv
// Testbench for dwt2d_haar_stream: directed corner cases plus random rows,
// checked against an integer-arithmetic model of the pairwise Haar transform.
module tb_dwt2d_haar_stream;
    localparam int PIX_W = 8;
    localparam int N     = 8;
    localparam int CW    = PIX_W + 3;
    localparam int IDX_W = 4;
    localparam int BUS_W = (N/2) * CW;
    localparam int ROW_W = N * PIX_W;
    localparam int BOUND = 200;

    typedef struct {
        logic [BUS_W-1:0] ll, hl, lh, hh;
        logic             last;
        logic [IDX_W-1:0] idx;
    } beat_t;

    logic clk;
    logic rst_n;
    int   vectors;
    int   miscompares;

    dwt2d_haar_stream_if #(.PIX_W(PIX_W), .N(N), .CW(CW), .IDX_W(IDX_W)) bus ();

    dwt2d_haar_stream #(.PIX_W(PIX_W), .N(N), .CW(CW), .IDX_W(IDX_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Free-running clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    bit             m_have_even;
    logic [ROW_W-1:0] m_even_row;
    logic           m_even_mode;
    int             m_pairs;
    bit             m_err;
    beat_t          exp_q[$];

    task automatic check_output(input string tag, input logic [63:0] observed,
                                input logic [63:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    function automatic int floor_div4(input int x);
        if (x >= 0) return x / 4;
        return -((-x + 3) / 4);
    endfunction

    function automatic int pix(input logic [ROW_W-1:0] row, input int i);
        return int'(row[i*PIX_W +: PIX_W]);
    endfunction

    function automatic beat_t model_beat(input logic [ROW_W-1:0] a, input logic [ROW_W-1:0] b,
                                         input logic m);
        beat_t r;
        int ll, hl, lh, hh;
        r.ll = '0; r.hl = '0; r.lh = '0; r.hh = '0; r.last = 1'b0; r.idx = '0;
        for (int k = 0; k < N/2; k++) begin
            ll = pix(a, 2*k) + pix(a, 2*k+1) + pix(b, 2*k) + pix(b, 2*k+1);
            hl = (pix(a, 2*k) - pix(a, 2*k+1)) + (pix(b, 2*k) - pix(b, 2*k+1));
            lh = (pix(a, 2*k) + pix(a, 2*k+1)) - (pix(b, 2*k) + pix(b, 2*k+1));
            hh = (pix(a, 2*k) - pix(a, 2*k+1)) - (pix(b, 2*k) - pix(b, 2*k+1));
            if (m) begin
                ll = floor_div4(ll); hl = floor_div4(hl);
                lh = floor_div4(lh); hh = floor_div4(hh);
            end
            r.ll[k*CW +: CW] = ll[CW-1:0];
            r.hl[k*CW +: CW] = hl[CW-1:0];
            r.lh[k*CW +: CW] = lh[CW-1:0];
            r.hh[k*CW +: CW] = hh[CW-1:0];
        end
        return r;
    endfunction

    // Model reaction to one accepted row.
    function automatic void model_accept(input logic [ROW_W-1:0] row, input logic last,
                                         input logic m);
        beat_t b;
        if (!m_have_even) begin
            if (last) begin
                m_err   = 1'b1;
                m_pairs = 0;
            end else begin
                m_have_even = 1'b1;
                m_even_row  = row;
                m_even_mode = m;
            end
        end else begin
            b      = model_beat(m_even_row, row, m_even_mode);
            b.last = last;
            b.idx  = IDX_W'(m_pairs % (1 << IDX_W));
            exp_q.push_back(b);
            m_pairs     = last ? 0 : m_pairs + 1;
            m_have_even = 1'b0;
        end
    endfunction

    function automatic void model_reset();
        m_have_even = 1'b0;
        m_pairs     = 0;
        m_err       = 1'b0;
        exp_q.delete();
    endfunction

    function automatic logic [ROW_W-1:0] make_row(input int pe, input int po);
        logic [ROW_W-1:0] r;
        for (int i = 0; i < N/2; i++) begin
            r[(2*i)*PIX_W +: PIX_W]   = pe[PIX_W-1:0];
            r[(2*i+1)*PIX_W +: PIX_W] = po[PIX_W-1:0];
        end
        return r;
    endfunction

    function automatic logic [ROW_W-1:0] rand_row();
        logic [ROW_W-1:0] r;
        for (int i = 0; i < N; i++) r[i*PIX_W +: PIX_W] = PIX_W'($urandom_range(0, (1 << PIX_W) - 1));
        return r;
    endfunction

    // Offer one row until it is accepted (inputs change just after the rising edge).
    task automatic apply_stimulus(input logic [ROW_W-1:0] row, input logic last, input logic m,
                                  input bit rand_ready);
        bit done = 1'b0;
        int waited = 0;
        bus.in_valid = 1'b1;
        bus.in_row   = row;
        bus.in_last  = last;
        bus.mode     = m;
        while (!done && waited < BOUND) begin
            @(negedge clk);
            if (bus.in_ready === 1'b1) begin
                model_accept(row, last, m);
                done = 1'b1;
            end
            @(posedge clk); #1;
            if (!done && rand_ready) bus.out_ready = 1'($urandom_range(0, 1));
            waited++;
        end
        bus.in_valid = 1'b0;
        check_output("row_accept_timeout", 64'(done), 64'd1);
    endtask

    task automatic drain();
        int w = 0;
        bus.out_ready = 1'b1;
        while (exp_q.size() != 0 && w < BOUND) begin
            @(posedge clk); #1;
            w++;
        end
        check_output("drain_pending", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic check_lane0(input string tag, input int ll, input int hl, input int lh,
                               input int hh);
        logic [CW-1:0] e;
        e = ll[CW-1:0]; check_output({tag, "_ll"}, 64'(bus.out_ll[CW-1:0]), 64'(e));
        e = hl[CW-1:0]; check_output({tag, "_hl"}, 64'(bus.out_hl[CW-1:0]), 64'(e));
        e = lh[CW-1:0]; check_output({tag, "_lh"}, 64'(bus.out_lh[CW-1:0]), 64'(e));
        e = hh[CW-1:0]; check_output({tag, "_hh"}, 64'(bus.out_hh[CW-1:0]), 64'(e));
    endtask

    // Directed pair held in the output register for a lane-0 constant check.
    task automatic held_pair(input string tag, input logic [ROW_W-1:0] a,
                             input logic [ROW_W-1:0] b, input logic m,
                             input int ll, input int hl, input int lh, input int hh);
        bus.out_ready = 1'b0;
        apply_stimulus(a, 1'b0, m, 1'b0);
        check_output({tag, "_valid_before"}, 64'(bus.out_valid), 64'd0);
        apply_stimulus(b, 1'b0, !m, 1'b0);
        check_output({tag, "_valid_after"}, 64'(bus.out_valid), 64'd1);
        check_lane0(tag, ll, hl, lh, hh);
        drain();
    endtask

    // Scoreboard: every accepted beat must match the oldest expected beat.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                check_output("unexpected_beat", 64'(bus.out_valid), 64'd0);
            end else begin
                check_output("beat_ll",   64'(bus.out_ll),   64'(exp_q[0].ll));
                check_output("beat_hl",   64'(bus.out_hl),   64'(exp_q[0].hl));
                check_output("beat_lh",   64'(bus.out_lh),   64'(exp_q[0].lh));
                check_output("beat_hh",   64'(bus.out_hh),   64'(exp_q[0].hh));
                check_output("beat_last", 64'(bus.out_last), 64'(exp_q[0].last));
                check_output("beat_idx",  64'(bus.out_idx),  64'(exp_q[0].idx));
                void'(exp_q.pop_front());
            end
        end
    end

    // Directed sequence followed by randomized traffic.
    initial begin
        logic [ROW_W-1:0] ra, rb;
        logic [BUS_W-1:0] first_ll, second_ll;

        vectors = 0; miscompares = 0;
        rst_n = 1'b0;
        bus.in_valid = 1'b0; bus.in_row = '0; bus.in_last = 1'b0;
        bus.mode = 1'b0; bus.out_ready = 1'b0;
        model_reset();

        repeat (2) @(posedge clk);
        @(negedge clk);
        check_output("reset_in_ready", 64'(bus.in_ready), 64'd0);
        check_output("reset_valid", 64'(bus.out_valid), 64'd0);
        check_output("reset_ll", 64'(bus.out_ll), 64'd0);
        check_output("reset_hh", 64'(bus.out_hh), 64'd0);
        check_output("reset_idx", 64'(bus.out_idx), 64'd0);
        check_output("reset_err", 64'(bus.err_odd), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check_output("idle_in_ready", 64'(bus.in_ready), 64'd1);
        @(posedge clk); #1;

        $display("[TB] directed coefficient values");
        held_pair("raw", make_row(10, 20), make_row(30, 40), 1'b0, 100, -20, -40, 0);
        held_pair("norm", make_row(10, 20), make_row(30, 40), 1'b1, 25, -5, -10, 0);
        held_pair("floor", make_row(0, 3), make_row(0, 0), 1'b1, 0, -1, 0, -1);
        held_pair("max", make_row(255, 255), make_row(255, 255), 1'b0, 1020, 0, 0, 0);
        held_pair("diag", make_row(255, 0), make_row(0, 255), 1'b0, 510, 0, 0, 510);

        $display("[TB] backpressure");
        bus.out_ready = 1'b0;
        apply_stimulus(rand_row(), 1'b0, 1'b0, 1'b0);
        apply_stimulus(rand_row(), 1'b0, 1'b1, 1'b0);
        first_ll = exp_q[0].ll;
        @(negedge clk);
        check_output("bp_even_ready", 64'(bus.in_ready), 64'd1);
        @(posedge clk); #1;
        apply_stimulus(rand_row(), 1'b0, 1'b1, 1'b0);
        rb = rand_row();
        bus.in_valid = 1'b1; bus.in_row = rb; bus.in_last = 1'b0; bus.mode = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check_output("bp_odd_stalled", 64'(bus.in_ready), 64'd0);
            check_output("bp_beat_held", 64'(bus.out_ll), 64'(first_ll));
            @(posedge clk); #1;
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        check_output("bp_release_ready", 64'(bus.in_ready), 64'd1);
        model_accept(rb, 1'b0, 1'b0);
        second_ll = exp_q[exp_q.size()-1].ll;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        check_output("bp_valid_stays", 64'(bus.out_valid), 64'd1);
        check_output("bp_second_loaded", 64'(bus.out_ll), 64'(second_ll));
        drain();

        $display("[TB] tile framing");
        apply_stimulus(rand_row(), 1'b0, 1'b0, 1'b0);
        apply_stimulus(rand_row(), 1'b1, 1'b0, 1'b0);
        for (int r = 0; r < 6; r++) apply_stimulus(rand_row(), 1'(r == 5), 1'($urandom_range(0, 1)), 1'b0);
        apply_stimulus(rand_row(), 1'b0, 1'b0, 1'b0);
        apply_stimulus(rand_row(), 1'b0, 1'b0, 1'b0);
        drain();

        $display("[TB] random traffic");
        for (int r = 0; r < 40; r++) apply_stimulus(rand_row(), 1'b0, 1'($urandom_range(0, 1)), 1'b1);
        for (int r = 0; r < 40; r++)
            apply_stimulus(rand_row(), 1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 1)), 1'b1);
        drain();
        if (m_have_even) apply_stimulus(rand_row(), 1'b0, 1'b0, 1'b0);
        drain();
        @(negedge clk);
        check_output("rand_err", 64'(bus.err_odd), 64'(m_err));
        @(posedge clk); #1;

        $display("[TB] odd-length tile");
        apply_stimulus(make_row(1, 2), 1'b0, 1'b0, 1'b0);
        apply_stimulus(make_row(3, 4), 1'b0, 1'b0, 1'b0);
        apply_stimulus(make_row(5, 6), 1'b1, 1'b0, 1'b0);
        drain();
        @(negedge clk);
        check_output("odd_tile_err", 64'(bus.err_odd), 64'd1);
        check_output("odd_tile_no_beat", 64'(bus.out_valid), 64'd0);
        @(posedge clk); #1;
        apply_stimulus(rand_row(), 1'b0, 1'b0, 1'b0);
        apply_stimulus(rand_row(), 1'b0, 1'b0, 1'b0);
        drain();

        $display("[TB] reset with buffered even row");
        ra = rand_row();
        apply_stimulus(ra, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b0;
        @(negedge clk);
        check_output("rst_in_ready", 64'(bus.in_ready), 64'd0);
        @(posedge clk); #1;
        @(negedge clk);
        check_output("rst_err_cleared", 64'(bus.err_odd), 64'd0);
        check_output("rst_valid", 64'(bus.out_valid), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        model_reset();
        bus.out_ready = 1'b0;
        apply_stimulus(make_row(10, 20), 1'b0, 1'b0, 1'b0);
        check_output("rst_even_first", 64'(bus.out_valid), 64'd0);
        apply_stimulus(make_row(30, 40), 1'b0, 1'b0, 1'b0);
        check_lane0("rst_pair", 100, -20, -40, 0);
        check_output("rst_pair_idx", 64'(bus.out_idx), 64'd0);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
